// File: rtl/wb_gpio_bank_if.sv
// Wishbone B4 pipelined bus bundle for wb_gpio_bank (32-bit data, 30-bit word address).
interface wb_gpio_bank_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [29:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_ack, o_wb_stall, o_wb_data
  );
endinterface

// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: LEDs, debounced switches, W1C change status, masked level interrupt.
// Define WB_GPIO_TOGGLE_EN to add the write-only LED_TOGGLE register at word address 4.
module wb_gpio_bank #(
  parameter int unsigned N_SW            = 16,
  parameter int unsigned N_LED           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  wb_gpio_bank_if.slave     wb,
  input  logic [N_SW-1:0]   i_switches,
  output logic [N_LED-1:0]  o_leds,
  output logic              o_int
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]  sync1_q, sync2_q, sample_q, deb_q, deb_d;
  logic [N_SW-1:0]  status_q, status_d, enable_q, enable_d, stat_set, stat_clr, stable;
  logic [N_LED-1:0] led_q, led_d;
  logic [CntW-1:0]  cnt_q;
  logic             primed_q, tick, accept, wr, ack_q, int_q;
  logic [31:0]      lane_mask, rdata_d, rdata_q;
  logic             unused_bits;

  assign accept    = wb.i_wb_cyc & wb.i_wb_stb;
  assign wr        = accept & wb.i_wb_we;
  assign tick      = (cnt_q == CntMax);
  assign lane_mask = {{8{wb.i_wb_sel[3]}}, {8{wb.i_wb_sel[2]}},
                      {8{wb.i_wb_sel[1]}}, {8{wb.i_wb_sel[0]}}};
  assign stable    = ~(sync2_q ^ sample_q);

  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_ack   = ack_q & wb.i_wb_cyc;
  assign wb.o_wb_data  = wb.o_wb_ack ? rdata_q : 32'h0;
  assign o_leds        = led_q;
  assign o_int         = int_q;

  assign unused_bits = ^{wb.i_wb_addr[29:3], wb.i_wb_data, lane_mask};

  // The priming tick loads the synchronised level directly, so switches already
  // high at power-up never look like an edge.
  always_comb begin
    deb_d    = deb_q;
    stat_set = '0;
    if (tick) begin
      if (!primed_q) begin
        deb_d = sync2_q;
      end else begin
        deb_d    = (deb_q & ~stable) | (sync2_q & stable);
        stat_set = deb_d ^ deb_q;
      end
    end
  end

  always_comb begin
    led_d    = led_q;
    enable_d = enable_q;
    stat_clr = '0;
    rdata_d  = '0;
    if (accept) begin
      case (wb.i_wb_addr[2:0])
        3'd0:    rdata_d[N_LED-1:0] = led_q;
        3'd1:    rdata_d[N_SW-1:0]  = deb_q;
        3'd2:    rdata_d[N_SW-1:0]  = status_q;
        3'd3:    rdata_d[N_SW-1:0]  = enable_q;
        default: rdata_d            = '0;
      endcase
    end
    if (wr) begin
      case (wb.i_wb_addr[2:0])
        3'd0: led_d = (led_q & ~lane_mask[N_LED-1:0]) |
                      (wb.i_wb_data[N_LED-1:0] & lane_mask[N_LED-1:0]);
        3'd2: stat_clr = wb.i_wb_data[N_SW-1:0] & lane_mask[N_SW-1:0];
        3'd3: enable_d = (enable_q & ~lane_mask[N_SW-1:0]) |
                         (wb.i_wb_data[N_SW-1:0] & lane_mask[N_SW-1:0]);
`ifdef WB_GPIO_TOGGLE_EN
        3'd4: led_d = led_q ^ (wb.i_wb_data[N_LED-1:0] & lane_mask[N_LED-1:0]);
`endif
        default: ;
      endcase
    end
    // A new edge beats a simultaneous W1C of the same bit.
    status_d = (status_q & ~stat_clr) | stat_set;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      deb_q    <= '0;
      status_q <= '0;
      enable_q <= '0;
      led_q    <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      int_q    <= 1'b0;
    end else begin
      sync1_q  <= i_switches;
      sync2_q  <= sync1_q;
      cnt_q    <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        sample_q <= sync2_q;
        primed_q <= 1'b1;
      end
      deb_q    <= deb_d;
      status_q <= status_d;
      enable_q <= enable_d;
      led_q    <= led_d;
      ack_q    <= accept;
      rdata_q  <= rdata_d;
      int_q    <= |(status_q & enable_q);
    end
  end

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Self-checking bench for wb_gpio_bank: directed scenarios plus random traffic against a cycle model.
module tb_wb_gpio_bank;
  localparam int unsigned NSw  = 16;
  localparam int unsigned NLed = 16;
  localparam int unsigned Deb  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSw-1:0]  sw = '0;
  logic [NSw-1:0]  sw_cur = '0;
  logic [NLed-1:0] leds;
  logic            irq;
  int unsigned     n_chk = 0;
  int unsigned     n_pass = 0;
  logic            last_ack;
  logic [31:0]     last_data;

  wb_gpio_bank_if bus ();

  wb_gpio_bank #(
    .N_SW            (NSw),
    .N_LED           (NLed),
    .DEBOUNCE_CYCLES (Deb)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .wb         (bus.slave),
    .i_switches (sw),
    .o_leds     (leds),
    .o_int      (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NSw-1:0]  s1, s2, smp, deb, stat, en;
    logic [NLed-1:0] led;
    logic            primed, intr, ack;
    logic [31:0]     rdata;
    logic [31:0]     edges;
  } mdl_t;

  mdl_t m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // State after one clock edge, from the register-level rules of the bank.
  function automatic mdl_t model_edge(input mdl_t c, input logic cyc, input logic stb,
                                      input logic we, input logic [2:0] a,
                                      input logic [31:0] d, input logic [3:0] sel,
                                      input logic [NSw-1:0] swv);
    mdl_t n = c;
    logic [31:0] mask;
    logic [NSw-1:0] newdeb, set, clr;
    bit tick, acc;
    for (int k = 0; k < 4; k++) mask[k*8 +: 8] = {8{sel[k]}};
    acc  = cyc & stb;
    tick = (c.edges % Deb) == Deb - 1;
    n.edges = c.edges + 1;
    n.s1 = swv;
    n.s2 = c.s1;
    newdeb = c.deb;
    set = '0;
    clr = '0;
    if (tick) begin
      if (!c.primed) newdeb = c.s2;
      else begin
        for (int i = 0; i < NSw; i++)
          if (c.s2[i] == c.smp[i]) newdeb[i] = c.s2[i];
        set = newdeb ^ c.deb;
      end
      n.smp = c.s2;
      n.primed = 1'b1;
    end
    n.deb  = newdeb;
    n.intr = |(c.stat & c.en);
    n.ack  = acc;
    n.rdata = 0;
    if (acc) begin
      case (a)
        3'd0: n.rdata = 32'(c.led);
        3'd1: n.rdata = 32'(c.deb);
        3'd2: n.rdata = 32'(c.stat);
        3'd3: n.rdata = 32'(c.en);
        default: n.rdata = 0;
      endcase
      if (we) begin
        case (a)
          3'd0: n.led = NLed'((c.led & ~mask) | (d & mask));
          3'd2: clr = NSw'(d & mask);
          3'd3: n.en = NSw'((c.en & ~mask) | (d & mask));
`ifdef WB_GPIO_TOGGLE_EN
          3'd4: n.led = NLed'(c.led ^ (d & mask));
`endif
          default: ;
        endcase
      end
    end
    n.stat = (c.stat & ~clr) | set;
    return n;
  endfunction

  task automatic step(input logic cyc, input logic stb, input logic we, input logic [2:0] a,
                      input logic [31:0] d, input logic [3:0] sel);
    logic exp_ack;
    bus.i_wb_cyc  = cyc;
    bus.i_wb_stb  = stb;
    bus.i_wb_we   = we;
    bus.i_wb_addr = {27'($urandom), a};
    bus.i_wb_data = d;
    bus.i_wb_sel  = sel;
    sw = sw_cur;
    #1;
    exp_ack   = m.ack & cyc;
    last_ack  = bus.o_wb_ack;
    last_data = bus.o_wb_data;
    check("ack", 32'(bus.o_wb_ack), 32'(exp_ack));
    check("rdata", bus.o_wb_data, exp_ack ? m.rdata : 32'h0);
    check("stall", 32'(bus.o_wb_stall), 32'h0);
    m = model_edge(m, cyc, stb, we, a, d, sel, sw_cur);
    @(posedge clk);
    #1;
    check("leds", 32'(leds), 32'(m.led));
    check("int", 32'(irq), 32'(m.intr));
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
  endtask

  task automatic wb_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd);
    step(1'b1, 1'b1, we, a, d, sel);
    step(1'b1, 1'b0, 1'b0, a, 32'h0, 4'h0);
    rd = last_data;
  endtask

  task automatic do_reset(input logic [NSw-1:0] swv);
    rst = 1'b1;
    sw_cur = swv;
    sw = swv;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    m = '0;
    #1;
    check("rst_ack", 32'(bus.o_wb_ack), 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_int", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bit found;
    mdl_t pk;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0;
    m = '0;

    // Switches high through reset: no spurious status.
    do_reset(16'hFFFF);
    idle(3 * Deb + 2);
    wb_xfer(1'b0, 3'd1, 0, 4'hF, rd);  check("pwr_sw", rd, 32'h0000FFFF);
    wb_xfer(1'b0, 3'd2, 0, 4'hF, rd);  check("pwr_status", rd, 32'h0);
    check("pwr_int", 32'(irq), 32'h0);

    // Byte-lane LED write and ack timing.
    step(1'b1, 1'b1, 1'b1, 3'd0, 32'hDEADBEEF, 4'b0011);
    check("ack_not_early", 32'(last_ack), 32'h0);
    step(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    check("ack_one_cycle", 32'(last_ack), 32'h1);
    check("leds_beef", 32'(leds), 32'h0000BEEF);
    idle(1);
    wb_xfer(1'b0, 3'd0, 0, 4'hF, rd);  check("led_readback", rd, 32'h0000BEEF);

    // Debounced rising edge, status and interrupt, then W1C.
    do_reset(16'h0000);
    idle(3 * Deb);
    wb_xfer(1'b1, 3'd3, 32'h1, 4'hF, rd);
    sw_cur = 16'h0001;
    idle(3 * Deb);
    wb_xfer(1'b0, 3'd1, 0, 4'hF, rd);  check("edge_sw", rd, 32'h1);
    wb_xfer(1'b0, 3'd2, 0, 4'hF, rd);  check("edge_status", rd, 32'h1);
    check("edge_int", 32'(irq), 32'h1);
    wb_xfer(1'b1, 3'd2, 32'h1, 4'hF, rd);
    idle(1);
    wb_xfer(1'b0, 3'd2, 0, 4'hF, rd);  check("w1c_status", rd, 32'h0);
    check("w1c_int", 32'(irq), 32'h0);

    // Three-cycle glitch cannot span two ticks.
    sw_cur = 16'h0009;
    idle(3);
    sw_cur = 16'h0001;
    idle(3 * Deb);
    wb_xfer(1'b0, 3'd1, 0, 4'hF, rd);  check("glitch_sw", rd, 32'h1);
    wb_xfer(1'b0, 3'd2, 0, 4'hF, rd);  check("glitch_status", rd, 32'h0);

    // W1C landing on the same edge as a new status set.
    sw_cur = 16'h0000;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      pk = model_edge(m, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, sw_cur);
      if (pk.stat[0] && !m.stat[0]) begin
        wb_xfer(1'b1, 3'd2, 32'h1, 4'hF, rd);
        found = 1;
      end else idle(1);
    end
    check("collide_found", 32'(found), 32'h1);
    wb_xfer(1'b0, 3'd2, 0, 4'hF, rd);  check("collide_status", rd, 32'h1);
    wb_xfer(1'b1, 3'd2, 32'hFFFF, 4'hF, rd);

    // LED toggle register (or its absence).
    wb_xfer(1'b1, 3'd0, 32'h00FF, 4'hF, rd);
    wb_xfer(1'b1, 3'd4, 32'h0F0F, 4'hF, rd);
`ifdef WB_GPIO_TOGGLE_EN
    check("toggle_leds", 32'(leds), 32'h0FF0);
`else
    check("toggle_leds", 32'(leds), 32'h00FF);
`endif
    wb_xfer(1'b0, 3'd4, 0, 4'hF, rd);  check("addr4_read", rd, 32'h0);

    // Aborted cycle drops the ack.
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 4'hF);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    check("abort_ack", 32'(last_ack), 32'h0);

    // Reset with an ack pending.
    step(1'b1, 1'b1, 1'b1, 3'd0, 32'h1234, 4'hF);
    do_reset(16'h00A5);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic c, s;
      if ($urandom_range(15) == 0)
        sw_cur = ($urandom_range(2) == 0) ? NSw'($urandom) : sw_cur ^ NSw'(1 << $urandom_range(NSw-1));
      c = ($urandom_range(3) != 0);
      s = c & $urandom_range(1);
      step(c, s, 1'(($urandom_range(1))), 3'($urandom_range(7)), $urandom, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_gpio_bank.md
Name: wb_gpio_bank

Overview:
- Parametrised Wishbone (pipelined, B4) GPIO peripheral; successor to the fixed 16-switch/16-LED slave.
- Widths are configurable. Adds debouncing, per-bit change detection with W1C status, interrupt masking and byte-lane writes.
- Sits on the CPU's I/O bus segment. Drives board LEDs, samples board switches and raises one level interrupt to the core.

Parameters:
- N_SW, 16, number of switch inputs (1..32).
- N_LED, 16, number of LED outputs (1..32).
- DEBOUNCE_CYCLES, 50000, clocks between debounce samples (>=1; 1 = sample every cycle).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  30  word address; only [2:0] decoded
- i_wb_data  in  32  write data
- i_wb_sel  in  4  byte lane select
- o_wb_ack  out  1  response
- o_wb_stall  out  1  always 0
- o_wb_data  out  32  read data
- i_switches  in  N_SW  raw asynchronous switch levels
- o_leds  out  N_LED  LED drive
- o_int  out  1  interrupt, level, active-high

Behaviour:
- Clocking and reset: single clock i_clk; reset is asynchronous, active-high, on i_reset.
- Reset values (all async on i_reset): o_wb_ack=0, o_wb_data=0, o_leds=0, o_int=0. Also cleared: 2FF sync chain, debounce sample register, debounced value, status, enable, tick counter, primed flag.
- Accept and response timing:
  - Request is accepted on any cycle with i_wb_cyc & i_wb_stb; o_wb_stall is constant 0.
  - o_wb_ack goes high exactly 1 cycle after acceptance; back-to-back requests give back-to-back acks.
  - If i_wb_cyc is low in the ack cycle, the ack is suppressed (aborted cycle).
- Read data:
  - o_wb_data is registered and reflects register contents at the accept cycle, i.e. before that request's write takes effect.
  - o_wb_data is 0 whenever ack is low.
  - Bits above the register width read 0.
- Register map, by i_wb_addr[2:0]:
  - 0 LED: R/W. Each byte k of the LED register is written only if i_wb_sel[k]. o_leds is driven directly from this register.
  - 1 SW: RO, debounced switch value. Writes are ignored.
  - 2 STATUS: W1C. Bit i is set on any change of debounced bit i. A written 1 clears the bit, subject to i_wb_sel. If a set and a clear hit the same bit in the same cycle, the set wins.
  - 3 ENABLE: R/W, N_SW bits, byte-lane writes.
  - 4-7: read 0, writes ignored (see Optional Feature for address 4).
- Synchroniser: i_switches passes through a 2-FF synchroniser; sync value = input delayed 2 cycles.
- Debounce:
  - The tick counter runs 0..DEBOUNCE_CYCLES-1 and pulses a tick on wrap.
  - On each tick: sample <= sync. For every bit where the new sample equals the previous sample, the debounced bit <= sample.
  - A level must therefore be stable across 2 consecutive ticks to propagate.
- Primed flag:
  - Cleared by reset; set on the first tick after reset.
  - Debounced changes occurring while not primed, or on the priming tick, do not set STATUS. This prevents spurious edges on switches that are already high at power-up.
- Interrupt: o_int is registered as |(STATUS & ENABLE), one cycle after the contributing update.
- Reset mid-transaction: a pending ack is dropped immediately; no partial register update is retained.

Optional Feature:
- Macro: WB_GPIO_TOGGLE_EN.
- When defined: address 4 becomes LED_TOGGLE, write-only, reads 0. A write XORs the write data into the LED register per enabled byte lane. A toggle takes one cycle, same as a plain LED write.
- When undefined: address 4 behaves like 5-7 (reads 0, writes ignored) and no XOR logic is generated.

Test Plan:
- Reset with i_switches=16'hFFFF held, then run 3 ticks -> SW reads 0xFFFF, STATUS reads 0, o_int=0.
- Write 0xDEADBEEF to addr 0 with sel=4'b0011 on a 16-bit LED bank -> o_leds=16'hBEEF the cycle after ack. Readback returns 0x0000BEEF. Ack occurs exactly 1 cycle after stb.
- ENABLE=0x0001; toggle i_switches[0] 0->1 and hold 2 ticks (DEBOUNCE_CYCLES=4) -> SW bit0=1, STATUS=0x0001, o_int=1. Write 0x1 to addr 2 -> STATUS=0, o_int=0.
- Glitch i_switches[3] high for 3 cycles (DEBOUNCE_CYCLES=4) -> SW and STATUS unchanged.
- Issue a W1C clear of bit0 in the same cycle a new debounced edge on bit0 updates STATUS -> STATUS bit0 remains 1.
- With WB_GPIO_TOGGLE_EN, LED=0x00FF, write 0x0F0F to addr 4 with sel=4'hF -> o_leds=0x0FF0. Without the macro -> o_leds stays 0x00FF and the addr-4 read returns 0.
